muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU. It executes the R-type
//  ops the ALU decoder leaves undefined: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
//  It owns the HI/LO registers. busy goes to the hazard unit, which stalls any MDU op or

---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one shift-add or restoring-subtract step per clock.
// States: IDLE | waiting for start, mthi/mtlo honoured;  RUN | WIDTH iteration steps;  FIN | sign fix, write HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic             div_q;
  logic             sign_a, sign_b, b_zero;
  logic [WIDTH-1:0] raw_a, b_abs, acc, mq;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             borrow;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Signedness is folded into the sign flags: unsigned ops latch both as 0.
  assign a_neg    = ~op[0] & srca[WIDTH-1];
  assign b_neg    = ~op[0] & srcb[WIDTH-1];
  assign a_abs    = a_neg ? -srca : srca;
  assign b_abs_in = b_neg ? -srcb : srcb;

  assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, b_abs} : '0);
  assign div_sh   = {acc, mq[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, b_abs};
  assign borrow   = div_diff[WIDTH+1];

  assign prod   = {acc, mq};
  assign prod_s = (sign_a ^ sign_b) ? -prod : prod;
  assign quo    = (sign_a ^ sign_b) ? -mq : mq;
  assign rem    = sign_a ? -acc : acc;

  // Divide by zero reports the dividend exactly as presented, not its magnitude.
  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (div_q) begin
      res_hi = b_zero ? raw_a : rem;
      res_lo = b_zero ? '1 : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      div_q  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      raw_a  <= '0;
      b_abs  <= '0;
      acc    <= '0;
      mq     <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            count  <= '0;
            div_q  <= op[1];
            sign_a <= a_neg;
            sign_b <= b_neg;
            b_zero <= (srcb == '0);
            raw_a  <= srca;
            b_abs  <= b_abs_in;
            acc    <= '0;
            mq     <= a_abs;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (div_q) begin
            acc <= borrow ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], ~borrow};
          end else begin
            {acc, mq} <= {mul_sum, mq[WIDTH-1:1]};
          end
        end
        FIN: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and done cycle are queued at start,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb, wdata;
  logic        wr_hi, wr_lo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, " hi"}, hi, e.hi);
        chk({e.name, " lo"}, lo, e.lo);
        chk({e.name, " latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    e.hi = eh; e.lo = el; e.cyc = cyc + 34; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom;
    chk({nm, " busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    issue(o, a, b, eh, el, nm);
    wait_idle(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset hi", hi, 32'h0);
      chk("reset lo", lo, 32'h0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
    end

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max");
    @(negedge clk);
    chk("done one cycle", {31'd0, done}, 32'd0);
    run_op(2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -7*3");
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min");
    run_op(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu shift");
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7");
    run_op(2'b10, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, "div by 0");
    run_op(2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div neg by 0");
    run_op(2'b11, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, "divu by 0");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div overflow");

    // Idle mthi/mtlo
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'h11111111;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h22222222;
    chk("mthi idle", hi, 32'h11111111);
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo idle", lo, 32'h22222222);

    // start together with mthi: start wins, hi stays stale during the op
    @(negedge clk);
    start = 1'b1; op = 2'b01; srca = 32'd3; srcb = 32'd5;
    wr_hi = 1'b1; wdata = 32'hDEADBEEF;
    begin
      exp_t e;
      e.hi = 32'h0; e.lo = 32'd15; e.cyc = cyc + 34; e.name = "multu 3*5 with mthi";
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    chk("start beats mthi", hi, 32'h11111111);
    wait_idle("multu 3*5");

    // start at cycle 10 and mthi at cycle 12 of a running op are ignored
    issue(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu ignore");
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; srca = 32'd1; srcb = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hFFFF0000;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi while busy", hi, 32'h0);
    wait_idle("multu ignore");
    repeat (3) @(negedge clk);

    // reset mid-divide abandons the op
    @(negedge clk);
    start = 1'b1; op = 2'b11; srca = 32'd100; srcb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) chk("abort no done", {31'd0, done}, 32'd0);
    end
    chk("abort quiet lo", lo, 32'h0);

    wr_hi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi after reset", hi, 32'hA5A5A5A5);
    chk("lo after mthi", lo, 32'h0);

    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
